ram_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port 256 x BitCount RAM, which has an inout data bus, st/oe strobes and a one-cycle registered read.
- Accepts word read/write requests from two requesters (port 0: instruction fetch, port 1: data/load-store).
- Grants one request at a time and drives the RAM strobe sequence.
- Returns read data and a one-cycle ack to the winning requester.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_arb_pick.sv | 37 +++
 rtl/ram_arbiter.sv | 131 +++++++++++++
 tb/tb_ram_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// State encoding, default widths and port ids used by ram_arbiter and ram_arb_pick.
package ram_arb_pkg;

    localparam int BIT_COUNT = 16;
    localparam int ADDR_BITS = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_DATA,
        DONE
    } arb_state_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection between the two requesters.
// RAM_ARB_ROUND_ROBIN_EN: alternate on contention using last_grant;
// otherwise port 0 has fixed priority and last_grant is ignored.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = req0 | req1;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // On contention the port that did not win last time goes next.
    always_comb begin
        grant_id = PORT0;
        if (req0 && req1)
            grant_id = ~last_grant;
        else if (req1)
            grant_id = PORT1;
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // Port 0 always wins when it asks.
    always_comb begin
        grant_id = PORT0;
        if (!req0 && req1)
            grant_id = PORT1;
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter and strobe sequencer for a single-port RAM with a
// registered read and an inout data bus. All RAM controls come from flops.
// Optional macro: RAM_ARB_ROUND_ROBIN_EN (round-robin on contention).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int BitCount = BIT_COUNT,
    parameter int AddrBits = ADDR_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                we0,
    input  logic [AddrBits-1:0] addr0,
    input  logic [BitCount-1:0] wdata0,
    output logic                ack0,
    output logic [BitCount-1:0] rdata0,
    input  logic                req1,
    input  logic                we1,
    input  logic [AddrBits-1:0] addr1,
    input  logic [BitCount-1:0] wdata1,
    output logic                ack1,
    output logic [BitCount-1:0] rdata1,
    output logic                ram_st,
    output logic                ram_oe,
    output logic [AddrBits-1:0] ram_addr,
    inout  wire  [BitCount-1:0] ram_data,
    output logic                busy
);

    arb_state_t          state;
    logic                grant_valid;
    logic                grant_id;
    logic                gid;
    logic                last_grant;
    logic                drive;
    logic [BitCount-1:0] wdata_q;
    logic                sel_we;
    logic [AddrBits-1:0] sel_addr;
    logic [BitCount-1:0] sel_wdata;

    ram_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign sel_we    = (grant_id == PORT1) ? we1    : we0;
    assign sel_addr  = (grant_id == PORT1) ? addr1  : addr0;
    assign sel_wdata = (grant_id == PORT1) ? wdata1 : wdata0;

    // Only the WR state enables the driver; the RAM owns the bus otherwise.
    assign ram_data = drive ? wdata_q : {BitCount{1'bz}};
    assign busy     = (state != IDLE);

    // Sequencer: each state sets the registered strobes for the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            ram_st   <= 1'b0;
            ram_oe   <= 1'b0;
            ram_addr <= '0;
            drive    <= 1'b0;
            wdata_q  <= '0;
            gid      <= PORT0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        gid      <= grant_id;
                        ram_addr <= sel_addr;
                        wdata_q  <= sel_wdata;
                        if (sel_we) begin
                            state  <= WR;
                            ram_st <= 1'b1;
                            drive  <= 1'b1;
                        end else begin
                            state  <= RD_ADDR;
                        end
                    end
                end
                WR: begin
                    ram_st <= 1'b0;
                    drive  <= 1'b0;
                    ack0   <= (gid == PORT0);
                    ack1   <= (gid == PORT1);
                    state  <= DONE;
                end
                RD_ADDR: begin
                    ram_oe <= 1'b1;
                    state  <= RD_DATA;
                end
                RD_DATA: begin
                    ram_oe <= 1'b0;
                    if (gid == PORT1)
                        rdata1 <= ram_data;
                    else
                        rdata0 <= ram_data;
                    ack0  <= (gid == PORT0);
                    ack1  <= (gid == PORT1);
                    state <= DONE;
                end
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Remember who completed last so contention alternates; port 0 goes first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_grant <= PORT1;
        else if (state == DONE)
            last_grant <= gid;
    end
`else
    assign last_grant = PORT1;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 256x16 registered-read RAM.
// The bus carries a pull-up so an undriven ram_data reads as 16'hFFFF.
module tb_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic        ram_st, ram_oe;
    logic [7:0]  ram_addr;
    tri1  [15:0] ram_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [256];
    logic [15:0] rbuf;

    localparam logic [15:0] FLOAT = 16'hFFFF;

    ram_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .ram_st(ram_st), .ram_oe(ram_oe), .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy)
    );

    // RAM model: store on st, read buffer reloads every edge, drives only on oe
    assign ram_data = ram_oe ? rbuf : 16'hzzzz;
    always @(posedge clk) begin
        if (ram_st) mem[ram_addr] <= ram_data;
        rbuf <= mem[ram_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one access and wait up to 20 cycles for the ack; lat=20 on timeout.
    task automatic access(input bit port, input bit we, input logic [7:0] a,
                          input logic [15:0] wd, output int lat,
                          output logic [15:0] rd, output int st_n, output int oe_n);
        @(negedge clk);
        if (port) begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
        else      begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
        lat = 0; st_n = 0; oe_n = 0; rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            st_n += int'(ram_st);
            oe_n += int'(ram_oe);
            if (port ? ack1 : ack0) begin
                rd = port ? rdata1 : rdata0;
                break;
            end
        end
        if (port) req1 = 0; else req0 = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        repeat (2) @(negedge clk);
        total++;
        if ({ack0, ack1, ram_st, ram_oe, busy} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00000", {ack0, ack1, ram_st, ram_oe, busy});
        end
        total++;
        if ({rdata0, rdata1, ram_addr} !== 40'h0) begin
            bad++; $display("FAIL reset_data: rdata0=%h rdata1=%h addr=%h want 0", rdata0, rdata1, ram_addr);
        end
        total++;
        if (ram_data !== FLOAT) begin
            bad++; $display("FAIL reset_bus: got %h want released (%h)", ram_data, FLOAT);
        end
        reset = 1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat, st_n, oe_n;
        logic [15:0] rd;
        access(0, 1, 8'h12, 16'hBEEF, lat, rd, st_n, oe_n);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL wr_latency: got %0d want 2", lat); end
        total++;
        if (st_n !== 1 || oe_n !== 0) begin
            bad++; $display("FAIL wr_strobes: st=%0d oe=%0d want 1 0", st_n, oe_n);
        end
        access(0, 0, 8'h12, 16'h0000, lat, rd, st_n, oe_n);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
        total++;
        if (rd !== 16'hBEEF) begin bad++; $display("FAIL rd_data: got %h want BEEF", rd); end
        total++;
        if (oe_n !== 1 || st_n !== 0) begin
            bad++; $display("FAIL rd_strobes: st=%0d oe=%0d want 0 1", st_n, oe_n);
        end
    endtask

    // Per-cycle {busy,st,oe,ack0} and bus value through a write then a read.
    task automatic test_bus();
        logic [3:0]  wexp [4] = '{4'b0000, 4'b1100, 4'b1001, 4'b0000};
        logic [15:0] wbus [4] = '{FLOAT, 16'h1234, FLOAT, FLOAT};
        logic [3:0]  rexp [5] = '{4'b0000, 4'b1000, 4'b1010, 4'b1001, 4'b0000};
        logic [15:0] rbus [5] = '{FLOAT, FLOAT, 16'h1234, FLOAT, FLOAT};
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) wdata0 = 16'h0000;
            #1;
            total++;
            if ({busy, ram_st, ram_oe, ack0} !== wexp[c] || ram_data !== wbus[c]) begin
                bad++;
                $display("FAIL bus_wr c%0d: ctl=%b bus=%h want ctl=%b bus=%h",
                         c, {busy, ram_st, ram_oe, ack0}, ram_data, wexp[c], wbus[c]);
            end
            if (c == 0) begin req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 16'h1234; end
            if (c == 2) req0 = 0;
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            total++;
            if ({busy, ram_st, ram_oe, ack0} !== rexp[c] || ram_data !== rbus[c]) begin
                bad++;
                $display("FAIL bus_rd c%0d: ctl=%b bus=%h want ctl=%b bus=%h",
                         c, {busy, ram_st, ram_oe, ack0}, ram_data, rexp[c], rbus[c]);
            end
            if (c == 0) begin req0 = 1; we0 = 0; addr0 = 8'h40; end
            if (c == 3) req0 = 0;
        end
    endtask

    task automatic test_contention();
        int lat, st_n, oe_n, grants, n_exp;
        logic [15:0] rd, exp_r0, exp_r1;
        logic exp_g;
        access(0, 1, 8'h01, 16'h1111, lat, rd, st_n, oe_n);
        access(0, 1, 8'h02, 16'h2222, lat, rd, st_n, oe_n);
        @(negedge clk); reset = 0;
        @(negedge clk); reset = 1;
        exp_r0 = 16'h0; exp_r1 = 16'h0; grants = 0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        n_exp = 4;
`else
        n_exp = 5;
`endif
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 8'h01;
        req1 = 1; we1 = 0; addr1 = 8'h02;
        for (int cyc = 0; cyc < 60 && grants < n_exp; cyc++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                exp_g = grants[0];
`else
                exp_g = (grants >= 4);
`endif
                total++;
                if ((ack0 && ack1) || ack1 !== exp_g) begin
                    bad++; $display("FAIL cont_grant #%0d: ack0=%b ack1=%b want port %0d", grants, ack0, ack1, exp_g);
                end
                if (exp_g) exp_r1 = 16'h2222; else exp_r0 = 16'h1111;
                total++;
                if (rdata0 !== exp_r0 || rdata1 !== exp_r1) begin
                    bad++; $display("FAIL cont_rdata #%0d: r0=%h r1=%h want %h %h", grants, rdata0, rdata1, exp_r0, exp_r1);
                end
                grants++;
                if (grants == 4) req0 = 0;
                if (grants == n_exp) req1 = 0;
            end
        end
        req0 = 0; req1 = 0;
        total++;
        if (grants !== n_exp) begin bad++; $display("FAIL cont_count: got %0d want %0d", grants, n_exp); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int lat, st_n, oe_n, acks;
        logic [15:0] rd;
        access(1, 1, 8'hFF, 16'hA5A5, lat, rd, st_n, oe_n);
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 8'hFF;
        repeat (2) @(negedge clk);
        total++;
        if (ram_oe !== 1'b1) begin bad++; $display("FAIL mid_oe: got %b want 1 in RD_DATA", ram_oe); end
        reset = 0;
        #1;
        total++;
        if ({ack0, ack1, ram_st, ram_oe, busy} !== 5'b0 || ram_addr !== 8'h0 ||
            rdata1 !== 16'h0 || ram_data !== FLOAT) begin
            bad++;
            $display("FAIL mid_reset: ctl=%b addr=%h r1=%h bus=%h want 00000 00 0000 %h",
                     {ack0, ack1, ram_st, ram_oe, busy}, ram_addr, rdata1, ram_data, FLOAT);
        end
        acks = 0;
        repeat (3) begin @(negedge clk); acks += int'(ack1); end
        req1 = 0; reset = 1;
        @(negedge clk);
        acks += int'(ack1);
        total++;
        if (acks !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_idle: acks=%0d busy=%b want 0 0", acks, busy);
        end
        access(1, 0, 8'hFF, 16'h0, lat, rd, st_n, oe_n);
        total++;
        if (lat !== 3 || rd !== 16'hA5A5) begin
            bad++; $display("FAIL mid_reread: lat=%0d data=%h want 3 A5A5", lat, rd);
        end
    endtask

    task automatic test_back_to_back();
        int lat, st_n, oe_n, gap;
        logic [15:0] rd;
        access(1, 1, 8'h30, 16'h3030, lat, rd, st_n, oe_n);
        access(1, 1, 8'h31, 16'h3131, lat, rd, st_n, oe_n);
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 8'h30;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack1) break;
        end
        total++;
        if (ack1 !== 1'b1 || rdata1 !== 16'h3030) begin
            bad++; $display("FAIL b2b_first: ack1=%b r1=%h want 1 3030", ack1, rdata1);
        end
        addr1 = 8'h31;
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            gap++;
            if (ack1) break;
        end
        req1 = 0;
        total++;
        if (gap !== 4 || rdata1 !== 16'h3131 || rdata0 !== 16'h0) begin
            bad++; $display("FAIL b2b_second: gap=%0d r1=%h r0=%h want 4 3131 0000", gap, rdata1, rdata0);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bus();
        test_contention();
        test_reset_mid_read();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
